// File: rtl/gear_ctrl_pkg.sv
// Shared types and default tuning values for the gear shift controller.
package gear_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_START,
    ST_NEUTRAL,
    ST_DRIVE,
    ST_SHIFT
  } state_e;

  typedef enum logic [1:0] {
    GEAR_N = 2'd0,
    GEAR_1 = 2'd1,
    GEAR_2 = 2'd2,
    GEAR_3 = 2'd3
  } gear_e;

  localparam int DEF_UP_TH        = 200;
  localparam int DEF_DN_TH        = 80;
  localparam int DEF_DEBOUNCE     = 3;
  localparam int DEF_SHIFT_CYCLES = 4;
  localparam int DEF_START_CYCLES = 8;

  localparam int TIMER_W = 8;
  localparam int DEB_W   = 8;

endpackage

// File: rtl/gear_shift_controller_if.sv
// Driver-side controls and engine/gearbox status of the gear shift controller.
interface gear_shift_controller_if;
  logic       A;
  logic       D;
  logic [7:0] rpm;
  logic [1:0] M;
  logic       AC;
  logic       busy;

  modport master (output A, D, rpm, input M, AC, busy);
  modport slave  (input A, D, rpm, output M, AC, busy);
endinterface

// File: rtl/cycle_timer.sv
// Down-counter shared by the crank and clutch-open delays; done on the last ticked cycle.
module cycle_timer
  import gear_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign done = tick && (cnt == TIMER_W'(1));

endmodule

// File: rtl/gear_shift_controller.sv
// Ignition/crank sequencing and debounced automatic 3-speed shifting with Moore outputs.
module gear_shift_controller
  import gear_ctrl_pkg::*;
#(
  parameter int UP_TH        = DEF_UP_TH,
  parameter int DN_TH        = DEF_DN_TH,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int SHIFT_CYCLES = DEF_SHIFT_CYCLES,
  parameter int START_CYCLES = DEF_START_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  gear_shift_controller_if.slave  bus
);

  if (UP_TH <= DN_TH) begin : g_bad_thresholds
    $error("UP_TH must be greater than DN_TH");
  end
  if (DEBOUNCE < 1 || SHIFT_CYCLES < 1 || START_CYCLES < 1 ||
      DEBOUNCE > 255 || SHIFT_CYCLES > 255 || START_CYCLES > 255) begin : g_bad_counts
    $error("DEBOUNCE, SHIFT_CYCLES and START_CYCLES must be in 1..255");
  end

  localparam logic [7:0]         UP_B    = 8'(UP_TH);
  localparam logic [7:0]         DN_B    = 8'(DN_TH);
  localparam logic [DEB_W-1:0]   DEB_B   = DEB_W'(DEBOUNCE);
  localparam logic [TIMER_W-1:0] SHIFT_B = TIMER_W'(SHIFT_CYCLES);
  localparam logic [TIMER_W-1:0] START_B = TIMER_W'(START_CYCLES);

  state_e             state;
  gear_e              gear;
  gear_e              target;
  logic [DEB_W-1:0]   deb_cnt;
  logic [DEB_W-1:0]   deb_next;
  logic               deb_up;
  logic               hi;
  logic               lo;
  logic               up_req;
  logic               dn_req;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hi       = bus.rpm >= UP_B;
    lo       = bus.rpm <= DN_B;
    deb_next = '0;
    if (hi || lo) begin
      // Same direction keeps counting (saturating); a direction change restarts at 1.
      if (deb_cnt != '0 && deb_up == hi)
        deb_next = (deb_cnt == DEB_B) ? deb_cnt : deb_cnt + DEB_W'(1);
      else
        deb_next = DEB_W'(1);
    end
    up_req = hi && (deb_next == DEB_B) && (gear != GEAR_3);
    dn_req = lo && (deb_next == DEB_B) && (gear > GEAR_1);

    timer_load = 1'b0;
    timer_val  = '0;
    if (!bus.A) begin
      timer_load = 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          timer_load = 1'b1;
          timer_val  = START_B;
        end
        ST_NEUTRAL: if (bus.D) begin
          timer_load = 1'b1;
          timer_val  = SHIFT_B;
        end
        ST_DRIVE: if (bus.D && (up_req || dn_req)) begin
          timer_load = 1'b1;
          timer_val  = SHIFT_B;
        end
        default: ;
      endcase
    end
  end

  cycle_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     ((state == ST_START) || (state == ST_SHIFT)),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_OFF;
      gear    <= GEAR_N;
      target  <= GEAR_N;
      deb_cnt <= '0;
      deb_up  <= 1'b0;
    end else if (!bus.A) begin
      state   <= ST_OFF;
      gear    <= GEAR_N;
      target  <= GEAR_N;
      deb_cnt <= '0;
      deb_up  <= 1'b0;
    end else begin
      case (state)
        ST_OFF:   state <= ST_START;
        ST_START: if (timer_done) state <= ST_NEUTRAL;
        ST_NEUTRAL: begin
          gear <= GEAR_N;
          if (bus.D) begin
            state  <= ST_SHIFT;
            target <= GEAR_1;
          end
        end
        ST_DRIVE: begin
          if (!bus.D) begin
            state   <= ST_NEUTRAL;
            gear    <= GEAR_N;
            deb_cnt <= '0;
          end else if (up_req) begin
            state   <= ST_SHIFT;
            target  <= gear_e'(gear + 2'd1);
            deb_cnt <= '0;
          end else if (dn_req) begin
            state   <= ST_SHIFT;
            target  <= gear_e'(gear - 2'd1);
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_next;
            deb_up  <= hi;
          end
        end
        ST_SHIFT: begin
          if (!bus.D) begin
            state  <= ST_NEUTRAL;
            gear   <= GEAR_N;
            target <= GEAR_N;
          end else if (timer_done) begin
            state   <= ST_DRIVE;
            gear    <= target;
            deb_cnt <= '0;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  assign bus.M    = (state == ST_DRIVE) ? gear : GEAR_N;
  assign bus.AC   = state inside {ST_NEUTRAL, ST_DRIVE, ST_SHIFT};
  assign bus.busy = (state == ST_START) || (state == ST_SHIFT);

endmodule

// File: tb/tb_gear_shift_controller.sv
// Directed bench for gear_shift_controller; outputs compared as {M, AC, busy}.
module tb_gear_shift_controller;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  gear_shift_controller_if bus ();

  gear_shift_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] obs;
  assign obs = {bus.M, bus.AC, bus.busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got {M,AC,busy}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 8 crank cycles with busy, then engine on in neutral.
  task automatic expect_start(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, "_crank"}, obs, 4'b00_0_1);
    end
    tick();
    check({tag, "_neutral"}, obs, 4'b00_1_0);
  endtask

  // Transition edge into SHIFT, 4 clutch-open cycles, then DRIVE in gear g.
  task automatic expect_shift(input string tag, input logic [1:0] g);
    for (int i = 0; i < 4; i++) begin
      tick();
      check({tag, "_shift"}, obs, 4'b00_1_1);
    end
    tick();
    check({tag, "_drive"}, obs, {g, 2'b10});
  endtask

  task automatic hold_drive(input string tag, input int n, input logic [1:0] g);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, obs, {g, 2'b10});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b1;
    bus.A   = 1'b0;
    bus.D   = 1'b0;
    bus.rpm = 8'd0;
    #1;
    check("reset_async", obs, 4'b00_0_0);
    tick();
    tick();
    check("reset_held", obs, 4'b00_0_0);
    reset = 1'b0;
    tick();
    check("off_wait_ignition", obs, 4'b00_0_0);

    // Startup
    bus.A = 1'b1;
    expect_start("startup");

    // Engage gear 1
    bus.D   = 1'b1;
    bus.rpm = 8'd50;
    expect_shift("engage", 2'b01);

    // Upshift debounce: two high cycles then mid-band clears the count
    bus.rpm = 8'd210;
    hold_drive("deb_two_high", 2, 2'b01);
    bus.rpm = 8'd150;
    hold_drive("deb_midband", 1, 2'b01);
    bus.rpm = 8'd210;
    hold_drive("up1_count", 2, 2'b01);
    expect_shift("up1", 2'b10);
    hold_drive("up2_count", 2, 2'b10);
    expect_shift("up2", 2'b11);
    bus.rpm = 8'd255;
    hold_drive("gear3_limit", 6, 2'b11);

    // Downshift at exactly DN_TH
    bus.rpm = 8'd80;
    hold_drive("dn1_count", 2, 2'b11);
    expect_shift("dn1", 2'b10);
    hold_drive("dn2_count", 2, 2'b10);
    expect_shift("dn2", 2'b01);
    bus.rpm = 8'd0;
    hold_drive("gear1_limit", 6, 2'b01);

    // Threshold boundaries
    bus.rpm = 8'd199;
    hold_drive("below_up_th", 4, 2'b01);
    bus.rpm = 8'd200;
    hold_drive("at_up_th_count", 2, 2'b01);
    expect_shift("at_up_th", 2'b10);
    bus.rpm = 8'd81;
    hold_drive("above_dn_th", 4, 2'b10);

    // Abort in cycle 2 of SHIFT
    bus.rpm = 8'd255;
    hold_drive("abort_count", 2, 2'b10);
    tick();
    check("abort_shift_c1", obs, 4'b00_1_1);
    tick();
    check("abort_shift_c2", obs, 4'b00_1_1);
    bus.D = 1'b0;
    tick();
    check("abort_to_neutral", obs, 4'b00_1_0);

    // Re-engage lands in gear 1 (aborted target discarded)
    bus.D   = 1'b1;
    bus.rpm = 8'd100;
    expect_shift("reengage", 2'b01);

    // Ignition off in DRIVE
    bus.A = 1'b0;
    tick();
    check("ignition_off", obs, 4'b00_0_0);
    tick();
    check("ignition_off_hold", obs, 4'b00_0_0);

    // Reset mid-shift is immediate
    bus.A = 1'b1;
    bus.D = 1'b1;
    expect_start("restart");
    tick();
    check("pre_reset_shift_c1", obs, 4'b00_1_1);
    tick();
    check("pre_reset_shift_c2", obs, 4'b00_1_1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_shift", obs, 4'b00_0_0);
    tick();
    check("reset_mid_shift_held", obs, 4'b00_0_0);
    reset = 1'b0;
    tick();
    check("post_reset_start", obs, 4'b00_0_1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gear_shift_controller.md
GEAR_SHIFT_CONTROLLER -- requirements
Module: gear_shift_controller

Interface
REQ-001 Parameter UP_TH, default 200: rpm at or above which an upshift is requested.
REQ-002 Parameter DN_TH, default 80: rpm at or below which a downshift is requested; UP_TH > DN_TH SHALL hold, checked at elaboration.
REQ-003 Parameter DEBOUNCE, default 3: consecutive cycles a threshold condition must persist before acting.
REQ-004 Parameter SHIFT_CYCLES, default 4: clutch-open cycles per gear change.
REQ-005 Parameter START_CYCLES, default 8: crank cycles from ignition to engine-on.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 A  input  1  ignition: 1 = on, 0 = off.
REQ-009 D  input  1  drive select: 1 = drive, 0 = neutral.
REQ-010 rpm  input  8  engine revolutions, unsigned, sampled every cycle.
REQ-011 M  output  2  engaged gear: 00 = neutral, 01/10/11 = gear 1/2/3.
REQ-012 AC  output  1  engine running.
REQ-013 busy  output  1  crank or shift in progress.

Function
REQ-014 The FSM SHALL have states OFF, START, NEUTRAL, DRIVE and SHIFT, plus a 2-bit gear register and a 2-bit target register.
REQ-015 Outputs SHALL be Moore: decoded from registered state only, so each output changes one cycle after the input edge that causes it.
REQ-016 A=0 SHALL force OFF on the next edge from any state, with highest priority; the counters and gear SHALL clear.
REQ-017 OFF: M=00, AC=0, busy=0; A=1 moves to START and loads the crank counter.
REQ-018 START: M=00, AC=0, busy=1; after exactly START_CYCLES cycles in START, move to NEUTRAL.
REQ-019 NEUTRAL: M=00, AC=1, busy=0, gear=0; D=1 moves to SHIFT with target=1.
REQ-020 DRIVE: M=gear, AC=1, busy=0; D=0 moves to NEUTRAL on the next edge, with priority over shift requests.
REQ-021 Upshift: rpm>=UP_TH for DEBOUNCE consecutive DRIVE cycles with gear<3 moves to SHIFT with target=gear+1.
REQ-022 Downshift: rpm<=DN_TH for DEBOUNCE consecutive DRIVE cycles with gear>1 moves to SHIFT with target=gear-1.
REQ-023 Gear limits: in gear 3, high rpm SHALL NOT change state; in gear 1, low rpm SHALL NOT change state. The debounce counter SHALL saturate, not wrap.
REQ-024 Debounce counter reset: rpm strictly between the thresholds SHALL clear the counter, as SHALL any change of condition direction.
REQ-025 SHIFT: M=00, AC=1, busy=1; after exactly SHIFT_CYCLES cycles, load gear=target, clear debounce, and enter DRIVE.
REQ-026 D=0 during SHIFT SHALL abort to NEUTRAL on the next edge; the target SHALL be discarded.
REQ-027 rpm SHALL be ignored in OFF, START, NEUTRAL and SHIFT; the debounce counter SHALL hold at 0 in these states.

Reset
REQ-028 reset=1 SHALL immediately set state=OFF, gear=0, target=0 and all counters=0, giving M=00, AC=0, busy=0, including when asserted mid-crank or mid-shift.
REQ-029 After reset deasserts, the first transition SHALL occur at the first rising edge on which A=1.

Structure
REQ-030 The state enum, gear encodings (NEUTRAL, G1, G2, G3) and default parameter values SHALL live in package gear_ctrl_pkg.
REQ-031 A single sub-module, cycle_timer (load value, tick, done), SHALL be shared by the START and SHIFT delays; debounce SHALL remain inline.

Verification
REQ-032 Startup: reset, A=1, D=0 -> AC=0 and busy=1 for 8 cycles, then AC=1, M=00.
REQ-033 Engage: from NEUTRAL, D=1, rpm=50 -> busy=1 and M=00 for 4 cycles, then M=01, busy=0.
REQ-034 Upshift with debounce: gear 1, rpm=210 for 2 cycles then 150 -> no shift; rpm=210 for 3 cycles -> SHIFT, then M=10 after 4 cycles; repeat -> M=11; further rpm=255 -> M stays 11.
REQ-035 Downshift: gear 3, rpm=80 for 3 cycles -> SHIFT, then M=10; at gear 1, rpm=0 indefinitely -> M stays 01.
REQ-036 Aborts: D=0 in cycle 2 of SHIFT -> NEUTRAL next edge, M=00, busy=0; A=0 in DRIVE -> M=00, AC=0 next edge.
REQ-037 Reset mid-shift: assert reset during SHIFT -> outputs 00/0/0 immediately, without waiting for a clock edge.
